mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter MAX_WAIT, default 4, meaning consecutive data grants won while fetch waits before fetch is forced to win.
REQ-002 The module SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The module SHALL have fetch ports: if_req in 1 request; if_addr in 32 byte address; if_gnt out 1 accepted; if_valid out 1 one-cycle response; if_rdata out 32 word.
REQ-005 The module SHALL have data ports: d_req in 1; d_we in 1 write; d_size in 2 (00 byte, 01 half, 10 word); d_sign in 1 load sign-extend; d_addr in 32; d_wdata in 32; d_gnt out 1; d_valid out 1; d_rdata out 32; d_misaligned out 1.
REQ-006 The module SHALL have memory ports: mem_req out 1; mem_we out 1; mem_addr out 32 (word-aligned, bits[1:0]=0); mem_be out 4; mem_wdata out 32; mem_ack in 1 one-cycle completion; mem_rdata in 32 (valid with mem_ack).

Function
REQ-007 The module SHALL implement states IDLE, BUSY_I, BUSY_D.
REQ-008 In IDLE, a request SHALL be accepted combinationally: x_gnt=1 in the same cycle as x_req=1 when x wins; at most one gnt per cycle; gnt=0 outside IDLE.
REQ-009 Arbitration SHALL be: data wins over fetch, unless the starvation counter equals MAX_WAIT, in which case fetch wins.
REQ-010 The starvation counter SHALL increment on each data grant made while if_req=1, SHALL clear on fetch grant, and SHALL saturate at MAX_WAIT.
REQ-011 On grant, all request fields SHALL be registered; requesters may change them after the grant cycle.
REQ-012 Fetch grant SHALL go to BUSY_I with mem_we=0 and mem_be=1111.
REQ-013 Aligned data grant SHALL go to BUSY_D.
REQ-014 Data access SHALL be misaligned when size=01 and addr[0]=1, size=10 and addr[1:0]!=0, or size=11.
REQ-015 Misaligned data grant SHALL stay in IDLE, issue no memory access, and pulse d_valid=1 and d_misaligned=1 in the next cycle with d_rdata=0.
REQ-016 In BUSY states, mem_req SHALL be 1 with stable mem_* outputs until mem_ack=1; mem_req SHALL be 0 in IDLE.
REQ-017 On mem_ack, the FSM SHALL return to IDLE, and x_valid SHALL pulse for exactly one cycle in the following cycle with registered data; a new grant is allowed in that cycle.
REQ-018 Write byte enables SHALL be: byte = 0001<<addr[1:0]; half = 0011<<(2*addr[1]); word = 1111.
REQ-019 Write data SHALL be: byte replicated 4x; half replicated 2x; word as-is.
REQ-020 Loads SHALL shift mem_rdata right by 8*addr[1:0] and then zero- or sign-extend from bit 7 (byte) or bit 15 (half) per d_sign; writes SHALL return d_rdata=0.
REQ-021 mem_ack received in IDLE SHALL be ignored.

Reset
REQ-022 While reset=1, the module SHALL go to IDLE and clear the starvation counter and the misaligned pending flag.
REQ-023 While reset=1, all outputs SHALL be 0.
REQ-024 Reset during BUSY SHALL abandon the transaction: no x_valid is produced afterward, and a late mem_ack is ignored.

Structure
REQ-025 The arbiter state enum and the mem_size encodings SHALL live in package common; MAX_WAIT stays a module parameter.
REQ-026 A combinational sub-module mem_lane_align SHALL produce byte enables, write replication and load extraction.
REQ-027 The FSM, registers and counter SHALL stay in mem_arbiter.

Verification
REQ-028 Fetch addr 0x100, mem_ack 3 cycles later with rdata 0xDEADBEEF -> if_gnt in cycle 0, mem_req high for 3 cycles, if_valid with 0xDEADBEEF one cycle after ack.
REQ-029 Data lb addr 0x203, d_sign=1, rdata 0x80112233 -> mem_addr 0x200, mem_be 1000, d_rdata 0xFFFFFF80; repeat with lbu -> d_rdata 0x00000080.
REQ-030 sh addr 0x302, wdata 0x0000ABCD -> mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1, d_valid one cycle after ack.
REQ-031 lw addr 0x401 -> d_gnt, no mem_req, d_valid=1 and d_misaligned=1 next cycle.
REQ-032 if_req and d_req both held high, MAX_WAIT=4 -> 4 data grants, then 1 fetch grant, then data grants resume.
REQ-033 reset=1 during BUSY_D before ack, then mem_ack -> no d_valid, FSM in IDLE, mem_req=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state type, access size
// encodings and the alignment rule used to reject illegal data accesses.
package common;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // A half must sit on an even byte, a word on a 4-byte boundary; size 11 is illegal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a sub-word data access and the 32-bit memory
// bus: byte enables, write-data replication and load extraction/extension.
module mem_lane_align
  import common::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [31:0] rdata_shift;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign rdata_shift = rdata >> {addr_lo, 3'b000};

  // Select lanes and extension by access size; word is the pass-through case.
  always_comb begin
    be          = 4'b1111;
    wdata_lanes = wdata;
    rdata_ext   = rdata_shift;
    case (size)
      SIZE_BYTE: begin
        be          = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{sign & rdata_shift[7]}}, rdata_shift[7:0]};
      end
      SIZE_HALF: begin
        be          = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{sign & rdata_shift[15]}}, rdata_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single memory port.
// Data normally wins; fetch is forced through after MAX_WAIT consecutive data
// grants taken while it was waiting. One transaction is outstanding at a time.
module mem_arbiter
  import common::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  arb_state_t    state_reg, state_next;
  logic [CW-1:0] starve_reg;
  logic [31:0]   addr_reg, wdata_reg, if_rdata_reg, d_rdata_reg;
  logic [1:0]    size_reg;
  logic          we_reg, sign_reg, mis_pend_reg, if_valid_reg, d_valid_reg;
  logic          grant_i, grant_d, d_mis, starved, busy, ack_i, ack_d;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata, lane_rdata;

  assign d_mis   = is_misaligned(d_size, d_addr[1:0]);
  assign starved = (starve_reg == CW'(MAX_WAIT));
  assign busy    = (state_reg != IDLE);
  assign ack_i   = (state_reg == BUSY_I) && mem_ack;
  assign ack_d   = (state_reg == BUSY_D) && mem_ack;

  // Arbitration in IDLE and return to IDLE on completion; acks in IDLE fall through.
  always_comb begin
    state_next = state_reg;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (if_req && (!d_req || starved)) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end else if (d_req) begin
          grant_d = 1'b1;
          if (!d_mis) state_next = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Capture the winning request and track how long fetch has been starved.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_reg   <= '0;
      mis_pend_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      size_reg     <= SIZE_WORD;
      we_reg       <= 1'b0;
      sign_reg     <= 1'b0;
    end else begin
      mis_pend_reg <= grant_d && d_mis;
      if (grant_i) begin
        starve_reg <= '0;
        addr_reg   <= if_addr;
        wdata_reg  <= '0;
        size_reg   <= SIZE_WORD;
        we_reg     <= 1'b0;
        sign_reg   <= 1'b0;
      end else if (grant_d) begin
        if (if_req && !starved) starve_reg <= starve_reg + 1'b1;
        addr_reg  <= d_addr;
        wdata_reg <= d_wdata;
        size_reg  <= d_size;
        we_reg    <= d_we;
        sign_reg  <= d_sign;
      end
    end
  end

  // One-cycle response pulses following the ack (or a rejected misaligned access).
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid_reg <= 1'b0;
      d_valid_reg  <= 1'b0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      if_valid_reg <= ack_i;
      d_valid_reg  <= ack_d || (grant_d && d_mis);
      if (ack_i) if_rdata_reg <= mem_rdata;
      if (ack_d)                  d_rdata_reg <= we_reg ? 32'h0 : lane_rdata;
      else if (grant_d && d_mis)  d_rdata_reg <= 32'h0;
    end
  end

  mem_lane_align u_align (
    .size        (size_reg),
    .sign        (sign_reg),
    .addr_lo     (addr_reg[1:0]),
    .wdata       (wdata_reg),
    .rdata       (mem_rdata),
    .be          (lane_be),
    .wdata_lanes (lane_wdata),
    .rdata_ext   (lane_rdata)
  );

  // Everything is forced low while reset is held, including the first reset cycle.
  assign if_gnt       = grant_i & ~reset;
  assign d_gnt        = grant_d & ~reset;
  assign if_valid     = if_valid_reg & ~reset;
  assign d_valid      = d_valid_reg & ~reset;
  assign d_misaligned = mis_pend_reg & ~reset;
  assign if_rdata     = reset ? 32'h0 : if_rdata_reg;
  assign d_rdata      = reset ? 32'h0 : d_rdata_reg;
  assign mem_req      = busy & ~reset;
  assign mem_we       = busy & we_reg & ~reset;
  assign mem_addr     = (busy && !reset) ? {addr_reg[31:2], 2'b00} : 32'h0;
  assign mem_be       = (busy && !reset) ? lane_be : 4'h0;
  assign mem_wdata    = (busy && !reset) ? lane_wdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized single-requester
// traffic, with the bench acting as the memory and predicting every response
// from the lane/extension rules in plain arithmetic.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk, reset;
  logic        if_req, if_gnt, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_sign, d_gnt, d_valid, d_misaligned;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_sign(d_sign), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .d_misaligned(d_misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Fetch transaction; starts and ends 1 time unit after a falling edge.
  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] rdata, input int dly);
    if_req = 1'b1; if_addr = addr;
    #1;
    chk("if_gnt", if_gnt, 1); chk("d_gnt_quiet", d_gnt, 0);
    @(negedge clk);
    if_req = 1'b0; if_addr = $urandom;
    #1;
    for (int k = 1; k <= dly; k++) begin
      chk("if_mem_req", mem_req, 1);
      chk("if_mem_addr", mem_addr, {addr[31:2], 2'b00});
      chk("if_mem_be", mem_be, 4'hF);
      chk("if_mem_we", mem_we, 0);
      chk("if_valid_early", if_valid, 0);
      if (k == dly) begin mem_ack = 1'b1; mem_rdata = rdata; end
      @(negedge clk); #1;
    end
    mem_ack = 1'b0; mem_rdata = $urandom;
    chk("if_req_drop", mem_req, 0);
    chk("if_valid", if_valid, 1);
    chk("if_rdata", if_rdata, rdata);
    @(negedge clk); #1;
    chk("if_valid_pulse", if_valid, 0);
    $display("fetch addr=%h rdata=%h dly=%0d", addr, rdata, dly);
  endtask

  // Data transaction; expected lanes and result computed from the access rules.
  task automatic run_data(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int dly);
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wexp, rexp, shifted;
    int          off, v;
    off = int'(addr[1:0]);
    mis = (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0) || size == 2'd3;
    shifted = rdata / (32'd1 << (8 * off));
    case (size)
      2'd0: begin
        be = 4'(1 << off);
        wexp = (wdata % 256) * 32'h01010101;
        v = int'(shifted % 256);
        if (sign && v >= 128) v = v - 256;
      end
      2'd1: begin
        be = (off >= 2) ? 4'hC : 4'h3;
        wexp = (wdata % 65536) * 32'h00010001;
        v = int'(shifted % 65536);
        if (sign && v >= 32768) v = v - 65536;
      end
      default: begin be = 4'hF; wexp = wdata; v = int'(rdata); end
    endcase
    rexp = we ? 32'h0 : 32'(v);

    d_req = 1'b1; d_we = we; d_size = size; d_sign = sign; d_addr = addr; d_wdata = wdata;
    #1;
    chk("d_gnt", d_gnt, 1); chk("if_gnt_quiet", if_gnt, 0);
    @(negedge clk);
    d_req = 1'b0; d_addr = $urandom; d_wdata = $urandom; d_size = 2'($urandom);
    d_we = 1'($urandom); d_sign = 1'($urandom);
    #1;
    if (mis) begin
      chk("mis_mem_req", mem_req, 0);
      chk("mis_valid", d_valid, 1);
      chk("mis_flag", d_misaligned, 1);
      chk("mis_rdata", d_rdata, 0);
    end else begin
      for (int k = 1; k <= dly; k++) begin
        chk("d_mem_req", mem_req, 1);
        chk("d_mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk("d_mem_be", mem_be, be);
        chk("d_mem_we", mem_we, we);
        if (we) chk("d_mem_wdata", mem_wdata, wexp);
        chk("d_valid_early", d_valid, 0);
        if (k == dly) begin mem_ack = 1'b1; mem_rdata = rdata; end
        @(negedge clk); #1;
      end
      mem_ack = 1'b0; mem_rdata = $urandom;
      chk("d_req_drop", mem_req, 0);
      chk("d_valid", d_valid, 1);
      chk("d_mis_clear", d_misaligned, 0);
      chk("d_rdata", d_rdata, rexp);
    end
    @(negedge clk); #1;
    chk("d_valid_pulse", d_valid, 0);
    $display("data we=%0d size=%0d sign=%0d addr=%h wdata=%h rdata=%h mis=%0d exp_rdata=%h",
             we, size, sign, addr, wdata, rdata, mis, rexp);
  endtask

  initial begin
    int wait_cnt;
    logic exp_f;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_sign = 1'b0; d_addr = 32'h0; d_wdata = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_if_gnt", if_gnt, 0); chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_req", mem_req, 0); chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0); chk("rst_d_mis", d_misaligned, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_be", mem_be, 0);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk); reset = 1'b0; #1;
    chk("post_rst_mem_req", mem_req, 0);
    $display("reset checked");

    run_fetch(32'h100, 32'hDEADBEEF, 3);
    run_data(1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 32'h80112233, 2);
    run_data(1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 32'h80112233, 1);
    run_data(1'b1, 2'd1, 1'b0, 32'h302, 32'h0000ABCD, 32'h0, 2);
    run_data(1'b0, 2'd2, 1'b0, 32'h401, 32'h0, 32'h0, 1);
    run_data(1'b0, 2'd3, 1'b0, 32'h400, 32'h0, 32'h0, 1);

    // Both requesters held: fetch only wins once it has watched MAX_WAIT data grants.
    reset = 1'b1; @(negedge clk); reset = 1'b0; #1;
    if_req = 1'b1; if_addr = 32'h600;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h500;
    wait_cnt = 0;
    for (int g = 0; g < 6; g++) begin
      #1;
      exp_f = (wait_cnt >= MAX_WAIT);
      chk("starve_if_gnt", if_gnt, exp_f);
      chk("starve_d_gnt", d_gnt, !exp_f);
      $display("starve grant %0d: exp_fetch=%0d if_gnt=%0d d_gnt=%0d", g, exp_f, if_gnt, d_gnt);
      if (exp_f) wait_cnt = 0; else wait_cnt++;
      @(negedge clk);
      if (g == 5) begin if_req = 1'b0; d_req = 1'b0; end
      #1; mem_ack = 1'b1; mem_rdata = $urandom;
      @(negedge clk); mem_ack = 1'b0;
    end
    @(negedge clk); #1;

    // Reset while a data access waits on memory; the late ack must be ignored.
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h700;
    #1; chk("abort_d_gnt", d_gnt, 1);
    @(negedge clk); d_req = 1'b0; #1;
    chk("abort_busy", mem_req, 1);
    reset = 1'b1; #1;
    chk("abort_rst_mem_req", mem_req, 0); chk("abort_rst_mem_we", mem_we, 0);
    @(negedge clk); reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678; #1;
    chk("abort_idle_mem_req", mem_req, 0);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("abort_no_valid", d_valid, 0); chk("abort_mem_req", mem_req, 0);
    @(negedge clk); #1;
    chk("abort_no_valid2", d_valid, 0);
    $display("reset abort checked");

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0)
        run_fetch($urandom, $urandom, int'($urandom_range(1, 3)));
      else
        run_data(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
